// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and helpers
// for the rotation-mode CORDIC engine.
package cordic_pkg;
  localparam int W = 16;
  localparam int ITERS = 16;
  localparam logic signed [W-1:0] ANG_MAX = 16'sd25736;
  localparam logic signed [W-1:0] CORDIC_K = 16'sd9949;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ROT  = 2'b01,
    HOLD = 2'b10
  } state_t;

  function automatic logic signed [W-1:0] sat_angle(
    input logic signed [W-1:0] a
  );
    if (a > ANG_MAX)
      return ANG_MAX;
    else if (a < -ANG_MAX)
      return -ANG_MAX;
    else
      return a;
  endfunction
endpackage

// File: rtl/cordic_rot_engine_if.sv
// Result handshake bundle: cos/sin pair
// with valid/ready flow control.
interface cordic_rot_engine_if;
  import cordic_pkg::*;

  logic                valid;
  logic                ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;

  modport master (
    output valid,
    output x_out,
    output y_out,
    input  ready
  );

  modport slave (
    input  valid,
    input  x_out,
    input  y_out,
    output ready
  );
endinterface

// File: rtl/cordic_atan_lut.sv
// Arctangent table atan(2^-i) in Q2.14,
// indexed by the iteration number.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [3:0]          idx,
  output logic signed [W-1:0] atan
);
  always_comb begin
    atan = '0;
    case (idx)
      4'd0:  atan = 16'sd12868;
      4'd1:  atan = 16'sd7596;
      4'd2:  atan = 16'sd4014;
      4'd3:  atan = 16'sd2037;
      4'd4:  atan = 16'sd1023;
      4'd5:  atan = 16'sd512;
      4'd6:  atan = 16'sd256;
      4'd7:  atan = 16'sd128;
      4'd8:  atan = 16'sd64;
      4'd9:  atan = 16'sd32;
      4'd10: atan = 16'sd16;
      4'd11: atan = 16'sd8;
      4'd12: atan = 16'sd4;
      4'd13: atan = 16'sd2;
      4'd14: atan = 16'sd1;
      4'd15: atan = 16'sd0;
      default: atan = '0;
    endcase
  end
endmodule

// File: rtl/cordic_rot_engine.sv
// Rotation-mode CORDIC datapath stepped by an
// external controller; result leaves via valid/ready.
module cordic_rot_engine
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic signed [W-1:0] angle_in,
  input  logic [3:0]          i,
  input  logic                step,
  input  logic                stop,
  output logic                comp,
  output logic                busy,
  cordic_rot_engine_if.master res
);
  state_t              state;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] z;
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic signed [W-1:0] atan;

  cordic_atan_lut u_lut (
    .idx  (i),
    .atan (atan)
  );

  // Direction comes from the z register only
  assign comp = ~z[W-1];
  assign x_sh = x >>> i;
  assign y_sh = y >>> i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      busy      <= 1'b0;
      res.valid <= 1'b0;
      res.x_out <= '0;
      res.y_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            x     <= CORDIC_K;
            y     <= '0;
            z     <= sat_angle(angle_in);
            busy  <= 1'b1;
            state <= ROT;
          end
        end
        ROT: begin
          if (stop) begin
            busy      <= 1'b0;
            res.valid <= 1'b1;
            res.x_out <= x;
            res.y_out <= y;
            state     <= HOLD;
          end else if (step) begin
            if (comp) begin
              x <= x - y_sh;
              y <= y + x_sh;
              z <= z - atan;
            end else begin
              x <= x + y_sh;
              y <= y - x_sh;
              z <= z + atan;
            end
          end
        end
        HOLD: begin
          if (res.ready) begin
            res.valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          res.valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rot_engine.sv
// Directed self-checking bench for the CORDIC
// rotation engine, acting as controller and sink.
module tb_cordic_rot_engine;
  import cordic_pkg::*;

  logic                clk;
  logic                reset;
  logic                load;
  logic signed [W-1:0] angle_in;
  logic [3:0]          i;
  logic                step;
  logic                stop;
  logic                comp;
  logic                busy;
  int                  checks;
  int                  errors;

  cordic_rot_engine_if bus ();

  cordic_rot_engine dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .angle_in (angle_in),
    .i        (i),
    .step     (step),
    .stop     (stop),
    .comp     (comp),
    .busy     (busy),
    .res      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic signed [W-1:0] a);
    load = 1'b1;
    angle_in = a;
    tick();
    load = 1'b0;
  endtask

  task automatic do_steps(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      i = k[3:0];
      step = 1'b1;
      tick();
    end
    step = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_accept();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || bus.valid !== 1'b0 || comp !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b comp=%b want 0 0 1",
               busy, bus.valid, comp);
    end
    checks++;
    if (bus.x_out !== 16'sd0 || bus.y_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: x=%0d y=%0d want 0 0",
               bus.x_out, bus.y_out);
    end
  endtask

  task automatic test_basic();
    int xv, yv;
    do_load(16'sd0);
    checks++;
    if (comp !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_comp: comp=%b busy=%b want 1 1", comp, busy);
    end
    do_steps(0, 16);
    do_stop();
    checks++;
    if (bus.valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid: valid=%b busy=%b want 1 0", bus.valid, busy);
    end
    xv = int'(bus.x_out);
    yv = int'(bus.y_out);
    checks++;
    if (xv > 16392 || xv < 16376 || yv > 8 || yv < -8) begin
      errors++;
      $display("FAIL basic_result: x=%0d y=%0d want 16384 0 (+-8)", xv, yv);
    end
    do_accept();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: valid=%b want 0", bus.valid);
    end
  endtask

  task automatic test_angles();
    int xv, yv;
    do_load(16'sd12868);
    do_steps(0, 16);
    do_stop();
    xv = int'(bus.x_out);
    yv = int'(bus.y_out);
    checks++;
    if (xv > 11593 || xv < 11577 || yv > 11593 || yv < 11577) begin
      errors++;
      $display("FAIL pos_pi4: x=%0d y=%0d want 11585 11585 (+-8)", xv, yv);
    end
    do_accept();
    do_load(-16'sd12868);
    checks++;
    if (comp !== 1'b0) begin
      errors++;
      $display("FAIL neg_first_comp: comp=%b want 0", comp);
    end
    do_steps(0, 16);
    do_stop();
    xv = int'(bus.x_out);
    yv = int'(bus.y_out);
    checks++;
    if (xv > 11593 || xv < 11577 || yv > -11577 || yv < -11593) begin
      errors++;
      $display("FAIL neg_pi4: x=%0d y=%0d want 11585 -11585 (+-8)", xv, yv);
    end
    do_accept();
  endtask

  task automatic test_saturation();
    int xv, yv;
    do_load(16'sd30000);
    do_steps(0, 16);
    do_stop();
    xv = int'(bus.x_out);
    yv = int'(bus.y_out);
    checks++;
    if (xv > 8 || xv < -8 || yv > 16392 || yv < 16376) begin
      errors++;
      $display("FAIL saturation: x=%0d y=%0d want 0 16384 (+-8)", xv, yv);
    end
    do_accept();
  endtask

  task automatic test_backpressure();
    logic signed [W-1:0] xh, yh;
    int bad;
    do_load(16'sd12868);
    do_steps(0, 16);
    do_stop();
    xh = bus.x_out;
    yh = bus.y_out;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      load = c[0];
      angle_in = 16'sd0;
      step = 1'b1;
      stop = c[1];
      i = c[3:0];
      tick();
      checks++;
      if (bus.valid !== 1'b1 || busy !== 1'b0 ||
          bus.x_out !== xh || bus.y_out !== yh) begin
        errors++;
        bad++;
        $display("FAIL hold_c%0d: valid=%b busy=%b x=%0d y=%0d want 1 0 %0d %0d",
                 c, bus.valid, busy, bus.x_out, bus.y_out, xh, yh);
      end
    end
    step = 1'b0;
    stop = 1'b0;
    checks++;
    if (xh > 16'sd11593 || xh < 16'sd11577) begin
      errors++;
      $display("FAIL hold_value: x=%0d want 11585 (+-8)", xh);
    end
    load = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    load = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake_load: valid=%b busy=%b want 0 0",
               bus.valid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL load_not_queued: busy=%b want 0", busy);
    end
  endtask

  task automatic test_step_stop();
    do_load(16'sd0);
    do_steps(0, 1);
    checks++;
    if (comp !== 1'b0) begin
      errors++;
      $display("FAIL step0_comp: comp=%b want 0", comp);
    end
    i = 4'd1;
    step = 1'b1;
    stop = 1'b1;
    tick();
    step = 1'b0;
    stop = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.x_out !== 16'sd9949 ||
        bus.y_out !== 16'sd9949) begin
      errors++;
      $display("FAIL step_stop: valid=%b x=%0d y=%0d want 1 9949 9949",
               bus.valid, bus.x_out, bus.y_out);
    end
    do_accept();
  endtask

  task automatic test_reset_mid_run();
    do_load(-16'sd20000);
    do_steps(0, 5);
    checks++;
    if (comp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: comp=%b busy=%b want 0 1", comp, busy);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.valid !== 1'b0 || comp !== 1'b1 ||
        bus.x_out !== 16'sd0 || bus.y_out !== 16'sd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b comp=%b x=%0d y=%0d want 0 0 1 0 0",
               busy, bus.valid, comp, bus.x_out, bus.y_out);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    load = 1'b0;
    angle_in = '0;
    i = '0;
    step = 1'b0;
    stop = 1'b0;
    bus.ready = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_basic();
    test_angles();
    test_saturation();
    test_backpressure();
    test_step_stop();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_rot_engine.md
Name: cordic_rot_engine

Overview:
- Rotation-mode CORDIC datapath. It is the responder to the iteration controller.
- The controller supplies the iteration index `i`, the advance strobe `step` and the termination flag `stop`. The engine applies one micro-rotation per step and returns `comp`, the rotation direction (sign of the residual angle), which the controller consumes.
- Produces cos/sin of a loaded angle and hands the result downstream over a valid/ready handshake.

Parameters:
- W, 16, datapath width. x, y, z and angles are signed Q2.14.
- ANG_MAX, 25736, saturation bound for angle_in (π/2 in Q2.14).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load  in  1  start request; latches angle_in when in IDLE.
- angle_in  in  W  target angle, signed Q2.14 radians.
- i  in  4  iteration index from the controller (0..15).
- step  in  1  controller strobe: apply iteration i this cycle.
- stop  in  1  controller flag: iterations complete.
- comp  out  1  1 when z ≥ 0 (rotate counter-clockwise), 0 otherwise.
- busy  out  1  high in ROT.
- x_out  out  W  cos result, Q2.14.
- y_out  out  W  sin result, Q2.14.
- valid  out  1  result available.
- ready  in  1  downstream accepts the result.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; x=y=z=0; valid=0; busy=0; x_out=y_out=0.
  - comp therefore reads 1.
- comp = ~z[W-1], decoded from the z register only; no combinational path from the inputs.
- States and transitions:
  - IDLE:
    - On load=1: x←9949 (K=0.6072529), y←0, z←sat(angle_in); go to ROT next cycle.
    - sat() clamps to ±ANG_MAX.
  - ROT (busy=1):
    - If stop=1, go to HOLD with valid←1, x_out←x, y_out←y. No rotation is applied, even if step=1 in the same cycle (stop wins).
    - Else if step=1, apply one micro-rotation:
      - comp=1: x←x−(y>>>i), y←y+(x>>>i), z←z−atan[i].
      - comp=0: x←x+(y>>>i), y←y−(x>>>i), z←z+atan[i].
    - Arithmetic shifts. Wrap-around W-bit adds; no saturation is needed given the gain and input bound.
    - step=0: registers hold.
  - HOLD:
    - valid=1; x_out/y_out stable.
    - On valid&&ready, go to IDLE with valid←0 next cycle.
- Ignored inputs:
  - load outside IDLE is ignored (no re-latch, no queueing).
  - step/stop outside ROT are ignored.
- load in the same cycle as a HOLD→IDLE handshake is ignored; the requester must re-assert.
- Latency:
  - load→first usable comp: 1 cycle.
  - stop→valid: 1 cycle.
- Reset mid-operation aborts immediately to the reset values above.
- atan[i] table, Q2.14, i=0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0.

Decomposition:
- Shared package `cordic_pkg`:
  - W, ANG_MAX, CORDIC_K=9949.
  - State encoding: IDLE=2'b00, ROT=2'b01, HOLD=2'b10.
  - Iteration count 16.
- Sub-module `cordic_atan_lut`: combinational 4-bit index → W-bit atan constant.
- FSM and datapath stay in cordic_rot_engine.

Test Plan:
- Basic cos/sin: angle_in=0, load, 16 steps i=0..15, then stop → comp=1 on the first step; valid after 1 cycle; x_out=16384±8, y_out=0±8.
- Positive and negative angles:
  - angle_in=12868 (π/4), full run → x_out≈y_out≈11585±8.
  - angle_in=−12868 → comp=0 on the first step; x_out≈11585, y_out≈−11585 (±8).
- Saturation: angle_in=30000 → z clamps to 25736; result x_out=0±8, y_out=16384±8.
- Backpressure and ignored inputs:
  - Hold ready=0 for 10 cycles in HOLD → valid stays 1; x_out/y_out unchanged.
  - load pulses and step during this window are ignored.
  - ready=1 → valid=0 next cycle.
- Simultaneous step and stop: step=1,stop=1 in ROT → no rotation applied; x/y/z equal the pre-cycle values in x_out/y_out.
- Reset mid-run: drive reset=0 asynchronously after 5 steps → busy=0, valid=0, x_out=y_out=0, comp=1 without waiting for a clock edge.
